// File: rtl/mips_pkg.sv
// Shared constants, field layout and decoded-instruction type for the R-type core.
package mips_pkg;

  localparam int NUM_REGS  = 32;

  // Instruction field positions (LSB of each field).
  localparam int OP_LSB    = 26;
  localparam int RS_LSB    = 21;
  localparam int RT_LSB    = 16;
  localparam int RD_LSB    = 11;
  localparam int SHAMT_LSB = 6;
  localparam int FUNCT_LSB = 0;

  localparam logic [5:0] OP_RTYPE = 6'd0;

  localparam logic [5:0] F_SLL  = 6'd0;
  localparam logic [5:0] F_SRL  = 6'd2;
  localparam logic [5:0] F_SRA  = 6'd3;
  localparam logic [5:0] F_SLLV = 6'd4;
  localparam logic [5:0] F_SRLV = 6'd6;
  localparam logic [5:0] F_SRAV = 6'd7;
  localparam logic [5:0] F_ADD  = 6'd32;
  localparam logic [5:0] F_ADDU = 6'd33;
  localparam logic [5:0] F_SUB  = 6'd34;
  localparam logic [5:0] F_SUBU = 6'd35;
  localparam logic [5:0] F_AND  = 6'd36;
  localparam logic [5:0] F_OR   = 6'd37;
  localparam logic [5:0] F_XOR  = 6'd38;
  localparam logic [5:0] F_NOR  = 6'd39;
  localparam logic [5:0] F_SLT  = 6'd42;
  localparam logic [5:0] F_SLTU = 6'd43;

  // Unused funct code; a non-zero opcode is folded onto it so the ALU flags err.
  localparam logic [5:0] F_BAD  = 6'd63;

  typedef struct packed {
    logic [5:0] funct;
    logic [4:0] shamt;
    logic [4:0] rd;
    logic       wr_en;   // rd is a writable register (not $0)
  } dec_t;

  function automatic dec_t decode(input logic [31:0] instr);
    dec_t d;
    d.funct = (instr[OP_LSB +: 6] == OP_RTYPE) ? instr[FUNCT_LSB +: 6] : F_BAD;
    d.shamt = instr[SHAMT_LSB +: 5];
    d.rd    = instr[RD_LSB +: 5];
    d.wr_en = (instr[RD_LSB +: 5] != 5'd0);
    return d;
  endfunction

endpackage

// File: rtl/mips_alu.sv
// Combinational R-type ALU: shifts, add/sub with signed overflow, logic, set-less-than.
module mips_alu
  import mips_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [5:0]        funct,
  input  logic [4:0]        shamt,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] y,
  output logic              ovf,
  output logic              err
);

  localparam int SHW = $clog2(DATA_W);
  localparam int MSB = DATA_W - 1;

  logic [SHW-1:0]    sh_imm;
  logic [SHW-1:0]    sh_var;
  logic [DATA_W-1:0] sum;
  logic [DATA_W-1:0] diff;

  assign sh_imm = SHW'(shamt);
  assign sh_var = a[SHW-1:0];
  assign sum    = a + b;
  assign diff   = a - b;

  // Function select; unsupported codes give err with a zero result.
  always_comb begin
    // NOTE: every output gets a default first so no path through the case infers a latch.
    y   = '0;
    ovf = 1'b0;
    err = 1'b0;
    case (funct)
      F_SLL:  y = b << sh_imm;
      F_SRL:  y = b >> sh_imm;
      F_SRA:  y = $signed(b) >>> sh_imm;
      F_SLLV: y = b << sh_var;
      F_SRLV: y = b >> sh_var;
      F_SRAV: y = $signed(b) >>> sh_var;
      F_ADD: begin
        y   = sum;
        ovf = (a[MSB] == b[MSB]) && (sum[MSB] != a[MSB]);
      end
      F_SUB: begin
        y   = diff;
        ovf = (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB]);
      end
      F_ADDU: y = sum;
      F_SUBU: y = diff;
      F_AND:  y = a & b;
      F_OR:   y = a | b;
      F_XOR:  y = a ^ b;
      F_NOR:  y = ~(a | b);
      F_SLT:  y = DATA_W'($signed(a) < $signed(b));
      F_SLTU: y = DATA_W'(a < b);
      default: err = 1'b1;
    endcase
  end

endmodule

// File: rtl/mips_rtype_pipe.sv
// Two-stage R-type execution core: S1 captures decoded fields and forwarded
// operands, S2 holds the ALU result until the consumer takes it, then writes back.
module mips_rtype_pipe
  import mips_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [31:0]       instruction,
  output logic              result_valid,
  input  logic              result_ready,
  output logic [DATA_W-1:0] result,
  output logic [4:0]        result_rd,
  output logic              result_ovf,
  output logic              result_err,
  input  logic              cfg_we,
  input  logic [4:0]        cfg_addr,
  input  logic [DATA_W-1:0] cfg_data
);

  logic [DATA_W-1:0] regs [NUM_REGS];

  dec_t              in_dec;
  logic [4:0]        in_rs;
  logic [4:0]        in_rt;
  logic [DATA_W-1:0] op_a;
  logic [DATA_W-1:0] op_b;

  logic              s1_valid;
  dec_t              s1_dec;
  logic [DATA_W-1:0] s1_a;
  logic [DATA_W-1:0] s1_b;

  logic [DATA_W-1:0] alu_y;
  logic              alu_ovf;
  logic              alu_err;

  logic              s2_wr;
  logic              advance1;
  logic              advance2;
  logic              accept;
  logic              s1_fwd;
  logic              s2_fwd;
  logic              wb_en;

  assign in_dec = decode(instruction);
  assign in_rs  = instruction[RS_LSB +: 5];
  assign in_rt  = instruction[RT_LSB +: 5];

  assign advance2    = !result_valid || result_ready;
  assign advance1    = !s1_valid || advance2;
  assign instr_ready = advance1 && !cfg_we;
  assign accept      = instr_valid && instr_ready;

  // A stage forwards only when its result will actually reach the register file.
  assign s1_fwd = s1_valid && s1_dec.wr_en && !alu_ovf && !alu_err;
  assign s2_fwd = result_valid && s2_wr;
  assign wb_en  = s2_fwd && result_ready;

  // Operand priority: $0, then the nearer (S1) producer, then S2, then the file.
  assign op_a = (in_rs == 5'd0)                  ? '0     :
                (s1_fwd && s1_dec.rd == in_rs)   ? alu_y  :
                (s2_fwd && result_rd == in_rs)   ? result :
                                                   regs[in_rs];
  assign op_b = (in_rt == 5'd0)                  ? '0     :
                (s1_fwd && s1_dec.rd == in_rt)   ? alu_y  :
                (s2_fwd && result_rd == in_rt)   ? result :
                                                   regs[in_rt];

  mips_alu #(.DATA_W(DATA_W)) u_alu (
    .funct (s1_dec.funct),
    .shamt (s1_dec.shamt),
    .a     (s1_a),
    .b     (s1_b),
    .y     (alu_y),
    .ovf   (alu_ovf),
    .err   (alu_err)
  );

  // Register file: preload port plus writeback; writeback overrides a same-cycle preload.
  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: the file is cleared on reset because bring-up relies on all registers reading 0;
      // this costs a reset net per bit, so large memories normally skip it.
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else begin
      if (cfg_we && cfg_addr != 5'd0) regs[cfg_addr] <= cfg_data;
      if (wb_en)                      regs[result_rd] <= result;
    end
  end

  // S1: decode/operand capture on an accepted instruction; empties when it moves on.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (reset) begin
      s1_valid <= 1'b0;
      s1_dec   <= '0;
      s1_a     <= '0;
      s1_b     <= '0;
    end else if (advance1) begin
      s1_valid <= accept;
      if (accept) begin
        s1_dec <= in_dec;
        s1_a   <= op_a;
        s1_b   <= op_b;
      end
    end
  end

  // S2: result register, held while the consumer stalls.
  always_ff @(posedge clk) begin
    if (reset) begin
      result_valid <= 1'b0;
      result       <= '0;
      result_rd    <= '0;
      result_ovf   <= 1'b0;
      result_err   <= 1'b0;
      s2_wr        <= 1'b0;
    end else if (advance2) begin
      result_valid <= s1_valid;
      if (s1_valid) begin
        result     <= alu_y;
        result_rd  <= s1_dec.rd;
        result_ovf <= alu_ovf;
        result_err <= alu_err;
        s2_wr      <= s1_dec.wr_en && !alu_ovf && !alu_err;
      end
    end
  end

endmodule

// File: tb/tb_mips_rtype_pipe.sv
// Self-checking bench: directed scenarios plus randomized traffic, scored against
// a sequential instruction-set model (program-order execution on an array).
module tb_mips_rtype_pipe;

  localparam int FN_SLL = 0,  FN_SRL = 2,  FN_SRA = 3,  FN_SLLV = 4, FN_SRLV = 6, FN_SRAV = 7;
  localparam int FN_ADD = 32, FN_ADDU = 33, FN_SUB = 34, FN_SUBU = 35;
  localparam int FN_AND = 36, FN_OR = 37, FN_XOR = 38, FN_NOR = 39, FN_SLT = 42, FN_SLTU = 43;

  logic        clk = 1'b0;
  logic        reset;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instruction;
  logic        result_valid;
  logic        result_ready;
  logic [31:0] result;
  logic [4:0]  result_rd;
  logic        result_ovf;
  logic        result_err;
  logic        cfg_we;
  logic [4:0]  cfg_addr;
  logic [31:0] cfg_data;

  mips_rtype_pipe #(.DATA_W(32)) dut (
    .clk          (clk),
    .reset        (reset),
    .instr_valid  (instr_valid),
    .instr_ready  (instr_ready),
    .instruction  (instruction),
    .result_valid (result_valid),
    .result_ready (result_ready),
    .result       (result),
    .result_rd    (result_rd),
    .result_ovf   (result_ovf),
    .result_err   (result_err),
    .cfg_we       (cfg_we),
    .cfg_addr     (cfg_addr),
    .cfg_data     (cfg_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] res;
    logic [4:0]  rd;
    logic        ovf;
    logic        err;
  } exp_t;

  logic [31:0] mrf [32];     // architectural register state in program order
  exp_t        expq [$];     // results owed by the DUT, oldest first
  exp_t        seen [$];     // results observed at the output handshake
  int          checks = 0;
  int          errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] enc(input int op, input int rs, input int rt,
                                      input int rd, input int sh, input int fn);
    return {6'(op), 5'(rs), 5'(rt), 5'(rd), 5'(sh), 6'(fn)};
  endfunction

  function automatic logic [31:0] r3(input int fn, input int rd, input int rs, input int rt);
    return enc(0, rs, rt, rd, 0, fn);
  endfunction

  // Executes one instruction against the architectural state, ISA-level semantics.
  function automatic exp_t model_exec(input logic [31:0] ins);
    exp_t        e;
    logic [31:0] a, b;
    longint      sa, sb, s;
    longint unsigned ua, ub;
    int          sh_i, sh_v;
    a    = mrf[ins[25:21]];
    b    = mrf[ins[20:16]];
    sa   = longint'($signed(a));
    sb   = longint'($signed(b));
    ua   = {32'd0, a};
    ub   = {32'd0, b};
    sh_i = int'(ins[10:6]);
    sh_v = int'(a[4:0]);
    e.rd = ins[15:11];
    e.res = '0;
    e.ovf = 1'b0;
    e.err = 1'b0;
    if (ins[31:26] != 6'd0) e.err = 1'b1;
    else begin
      case (int'(ins[5:0]))
        FN_SLL:  e.res = 32'(ub * (64'd1 << sh_i));
        FN_SRL:  e.res = 32'(ub / (64'd1 << sh_i));
        FN_SRA:  e.res = 32'(sb >>> sh_i);
        FN_SLLV: e.res = 32'(ub * (64'd1 << sh_v));
        FN_SRLV: e.res = 32'(ub / (64'd1 << sh_v));
        FN_SRAV: e.res = 32'(sb >>> sh_v);
        FN_ADD: begin
          s = sa + sb;
          e.res = 32'(s);
          e.ovf = (s > 64'sh7FFF_FFFF) || (s < -64'sh8000_0000);
        end
        FN_SUB: begin
          s = sa - sb;
          e.res = 32'(s);
          e.ovf = (s > 64'sh7FFF_FFFF) || (s < -64'sh8000_0000);
        end
        FN_ADDU: e.res = 32'(ua + ub);
        FN_SUBU: e.res = 32'(ua - ub);
        FN_AND:  e.res = a & b;
        FN_OR:   e.res = a | b;
        FN_XOR:  e.res = a ^ b;
        FN_NOR:  e.res = ~(a | b);
        FN_SLT:  e.res = (sa < sb) ? 32'd1 : 32'd0;
        FN_SLTU: e.res = (ua < ub) ? 32'd1 : 32'd0;
        default: e.err = 1'b1;
      endcase
    end
    return e;
  endfunction

  // One clock: observe handshakes with the current inputs, update the model, advance.
  task automatic tick();
    bit   acc, hs;
    exp_t e;
    #1;
    acc = instr_valid && instr_ready;
    hs  = result_valid && result_ready;
    if (reset) begin
      expq.delete();
      for (int i = 0; i < 32; i++) mrf[i] = '0;
    end else begin
      if (hs) begin
        if (expq.size() == 0) check("unexpected_result", hs, 0);
        else begin
          e = expq.pop_front();
          check("result", result, e.res);
          check("result_rd", result_rd, e.rd);
          check("result_ovf", result_ovf, e.ovf);
          check("result_err", result_err, e.err);
          seen.push_back('{res: result, rd: result_rd, ovf: result_ovf, err: result_err});
        end
      end
      if (cfg_we && cfg_addr != 5'd0) mrf[cfg_addr] = cfg_data;
      if (acc) begin
        e = model_exec(instruction);
        expq.push_back(e);
        if (!e.ovf && !e.err && e.rd != 5'd0) mrf[e.rd] = e.res;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    instr_valid  = 1'b0;
    result_ready = 1'b1;
    for (int i = 0; i < 20 && (result_valid || expq.size() != 0); i++) tick();
    check("drain_valid", result_valid, 0);
    check("drain_pending", expq.size(), 0);
  endtask

  task automatic preload(input int addr, input logic [31:0] val);
    drain();
    cfg_we   = 1'b1;
    cfg_addr = 5'(addr);
    cfg_data = val;
    #1;
    check("cfg_blocks_ready", instr_ready, 0);
    tick();
    cfg_we = 1'b0;
  endtask

  // Issue one instruction with the consumer ready, drain, and return what came out.
  task automatic exec1(input logic [31:0] ins, output exp_t obs);
    seen.delete();
    result_ready = 1'b1;
    instruction  = ins;
    instr_valid  = 1'b1;
    #1;
    check("exec_ready", instr_ready, 1);
    tick();
    drain();
    check("exec_count", seen.size(), 1);
    obs = (seen.size() != 0) ? seen[0] : '{res: 'x, rd: 'x, ovf: 'x, err: 'x};
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t obs;
    int   fns [16] = '{0, 2, 3, 4, 6, 7, 32, 33, 34, 35, 36, 37, 38, 39, 42, 43};
    logic [31:0] corner [5] = '{32'h7FFF_FFFF, 32'h8000_0000, 32'h0, 32'hFFFF_FFFF, 32'h1};

    reset = 1'b1; instr_valid = 1'b0; instruction = '0; result_ready = 1'b1;
    cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0;
    for (int i = 0; i < 32; i++) mrf[i] = '0;
    repeat (2) tick();
    reset = 1'b0;
    #1;
    check("rst_valid", result_valid, 0);
    check("rst_result", result, 0);
    check("rst_rd", result_rd, 0);
    check("rst_ovf", result_ovf, 0);
    check("rst_err", result_err, 0);
    check("rst_ready", instr_ready, 1);

    // Basic add, two-cycle latency, then read back $3.
    preload(1, 32'd5);
    preload(2, 32'd7);
    result_ready = 1'b1;
    instruction  = r3(FN_ADD, 3, 1, 2);
    instr_valid  = 1'b1;
    #1;
    check("t1_ready", instr_ready, 1);
    tick();
    instr_valid = 1'b0;
    check("t1_not_yet", result_valid, 0);
    tick();
    check("t1_valid", result_valid, 1);
    check("t1_result", result, 12);
    check("t1_rd", result_rd, 3);
    drain();
    exec1(r3(FN_OR, 8, 3, 0), obs);
    check("t1_readback", obs.res, 12);

    // Dependent chain, distance-1 and distance-2 forwarding, no stall.
    seen.delete();
    result_ready = 1'b1;
    instr_valid  = 1'b1;
    instruction  = r3(FN_ADD, 3, 1, 2); #1; check("chain_ready0", instr_ready, 1); tick();
    instruction  = r3(FN_SUB, 4, 3, 1); #1; check("chain_ready1", instr_ready, 1); tick();
    instruction  = r3(FN_OR,  5, 4, 3); #1; check("chain_ready2", instr_ready, 1); tick();
    instr_valid  = 1'b0;
    drain();
    check("chain_count", seen.size(), 3);
    if (seen.size() == 3) begin
      check("chain_r0", seen[0].res, 12);
      check("chain_r1", seen[1].res, 7);
      check("chain_r2", seen[2].res, 15);
    end

    // Signed overflow suppresses the write; addu writes the same wrapped value.
    preload(1, 32'h7FFF_FFFF);
    preload(2, 32'd1);
    preload(3, 32'h0000_1234);
    exec1(r3(FN_ADD, 3, 1, 2), obs);
    check("ovf_result", obs.res, 32'h8000_0000);
    check("ovf_flag", obs.ovf, 1);
    exec1(r3(FN_OR, 9, 3, 0), obs);
    check("ovf_no_write", obs.res, 32'h0000_1234);
    exec1(r3(FN_ADDU, 3, 1, 2), obs);
    check("addu_result", obs.res, 32'h8000_0000);
    check("addu_ovf", obs.ovf, 0);
    exec1(r3(FN_OR, 9, 3, 0), obs);
    check("addu_written", obs.res, 32'h8000_0000);

    // Shifts, compares and unsupported encodings.
    preload(1, 32'hFFFF_FFF0);
    preload(10, 32'h0000_ABCD);
    exec1(enc(0, 0, 1, 6, 4, FN_SRA), obs);  check("sra", obs.res, 32'hFFFF_FFFF);
    exec1(enc(0, 0, 1, 6, 4, FN_SRL), obs);  check("srl", obs.res, 32'h0FFF_FFFF);
    exec1(r3(FN_SLT, 7, 1, 0), obs);         check("slt", obs.res, 1);
    exec1(r3(FN_SLTU, 7, 1, 0), obs);        check("sltu", obs.res, 0);
    exec1(r3(5, 10, 1, 2), obs);
    check("bad_funct_err", obs.err, 1);
    check("bad_funct_res", obs.res, 0);
    exec1(enc(8, 1, 2, 10, 0, FN_ADD), obs);
    check("bad_op_err", obs.err, 1);
    exec1(r3(FN_OR, 9, 10, 0), obs);
    check("err_no_write", obs.res, 32'h0000_ABCD);

    // Backpressure: S2 and S1 fill, input stalls, outputs hold, then drain in order.
    seen.delete();
    result_ready = 1'b0;
    instr_valid  = 1'b1;
    instruction  = r3(FN_ADDU, 11, 1, 1); #1; check("stall_ready0", instr_ready, 1); tick();
    instruction  = r3(FN_XOR, 12, 11, 1); #1; check("stall_ready1", instr_ready, 1); tick();
    instruction  = r3(FN_NOR, 13, 12, 0);
    for (int i = 0; i < 2; i++) begin
      #1;
      check("stall_ready_low", instr_ready, 0);
      check("stall_valid", result_valid, 1);
      check("stall_hold_res", result, (expq.size() != 0) ? expq[0].res : 32'hx);
      check("stall_hold_rd", result_rd, 11);
      tick();
    end
    result_ready = 1'b1;
    for (int i = 0; i < 5 && instr_valid; i++) begin
      #1;
      if (instr_ready) instr_valid_off_after_tick();
      else tick();
    end
    check("stall_released", instr_valid, 0);
    drain();
    check("stall_count", seen.size(), 3);
    if (seen.size() == 3) begin
      check("stall_r0", seen[0].res, 32'hFFFF_FFE0);
      check("stall_r1", seen[1].res, 32'h0000_0010);
      check("stall_r2", seen[2].res, 32'hFFFF_FFEF);
    end

    // Reset with both stages full discards everything and clears the file.
    preload(1, 32'd5);
    preload(2, 32'd7);
    result_ready = 1'b0;
    instr_valid  = 1'b1;
    instruction  = r3(FN_ADD, 3, 1, 2); tick();
    instruction  = r3(FN_ADD, 4, 1, 2); tick();
    check("pre_reset_full", result_valid, 1);
    instr_valid = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("post_reset_valid", result_valid, 0);
    for (int r = 1; r < 32; r++) begin
      exec1(r3(FN_OR, 9, r, 0), obs);
      check("post_reset_reg", obs.res, 0);
    end
    preload(1, 32'd5);
    preload(2, 32'd7);
    exec1(r3(FN_ADD, 0, 1, 2), obs);
    check("r0_write_result", obs.res, 12);
    exec1(r3(FN_OR, 9, 0, 0), obs);
    check("r0_stays_zero", obs.res, 0);

    // Randomized traffic with random backpressure, scored by the model in tick().
    for (int blk = 0; blk < 6; blk++) begin
      for (int r = 1; r < 8; r++)
        preload(r, ($urandom_range(0, 2) == 0) ? corner[$urandom_range(0, 4)] : $urandom());
      for (int c = 0; c < 150; c++) begin
        instr_valid  = ($urandom_range(0, 3) != 0);
        result_ready = ($urandom_range(0, 3) != 0);
        if ($urandom_range(0, 15) == 0)
          instruction = enc($urandom_range(0, 1) * 9, $urandom_range(0, 7), $urandom_range(0, 7),
                            $urandom_range(0, 7), $urandom_range(0, 31), $urandom_range(8, 31));
        else
          instruction = enc(0, $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7),
                            $urandom_range(0, 31), fns[$urandom_range(0, 15)]);
        tick();
      end
      drain();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Accept the offered instruction this cycle and stop offering afterwards.
  task automatic instr_valid_off_after_tick();
    tick();
    instr_valid = 1'b0;
  endtask

endmodule
